register_arbiter: RTL

REGISTER_ARBITER -- requirements
Module: register_arbiter

---
 rtl/register_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/register_arbiter.sv
// Round-robin arbiter for a shared register: write/clear strobes, 1-cycle latency, registered outputs.
// Optional bus locking with a burst cap is enabled by defining REGISTER_ARBITER_LOCK_EN.
module register_arbiter #(
  parameter int BITWIDTH = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [NREQ-1:0]          iReq,
  input  logic [NREQ*BITWIDTH-1:0] iData,
  input  logic                     iClrReq,
`ifdef REGISTER_ARBITER_LOCK_EN
  input  logic [NREQ-1:0]          iLock,
`endif
  output logic [NREQ-1:0]          oGnt,
  output logic                     oEn,
  output logic                     oClr,
  output logic [BITWIDTH-1:0]      oData
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t        state;
  logic [PW-1:0] lastWin, rrWin, cand, win;
  logic          found;
  logic          anyReq;

  assign anyReq = |iReq;

  // Search starts one past the last winner, so the last winner is considered last.
  always_comb begin
    rrWin = lastWin;
    cand  = lastWin;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(lastWin) + i) % NREQ);
      if (!found && iReq[cand]) begin
        rrWin = cand;
        found = 1'b1;
      end
    end
  end

`ifdef REGISTER_ARBITER_LOCK_EN
  localparam int CW = $clog2(MAXBURST + 1);
  logic [CW-1:0] burstCnt;
  logic          lockHit;

  // The owner keeps the bus only while it is the active writer and under its burst cap.
  assign lockHit = (state == WRITE) && iReq[lastWin] && iLock[lastWin] &&
                   (burstCnt < CW'(MAXBURST));
  assign win     = lockHit ? lastWin : rrWin;
`else
  assign win     = rrWin;
`endif

  // Strobes are decodes of the state register; no input reaches an output combinationally.
  assign oEn  = (state == WRITE);
  assign oClr = (state == CLEAR);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      oGnt    <= '0;
      oData   <= '0;
      lastWin <= PW'(NREQ - 1);
`ifdef REGISTER_ARBITER_LOCK_EN
      burstCnt <= '0;
`endif
    end else if (iClrReq) begin
      state <= CLEAR;
      oGnt  <= '0;
`ifdef REGISTER_ARBITER_LOCK_EN
      burstCnt <= '0;
`endif
    end else if (anyReq) begin
      state   <= WRITE;
      oGnt    <= NREQ'(1) << win;
      oData   <= iData[int'(win)*BITWIDTH +: BITWIDTH];
      lastWin <= win;
`ifdef REGISTER_ARBITER_LOCK_EN
      burstCnt <= lockHit ? burstCnt + CW'(1) : CW'(1);
`endif
    end else begin
      state <= IDLE;
      oGnt  <= '0;
`ifdef REGISTER_ARBITER_LOCK_EN
      burstCnt <= '0;
`endif
    end
  end
endmodule
